fmap_serializer: RTL and testbench

Captures the final pooled binary feature maps of the BNN pipeline (the parallel per-channel output of the second max-pool stage) in a single cycle. Streams them off-chip as fixed-width beats over a valid/ready handshake. This is the read-out end of the feature-map interface: the conv/pool chain produces a wide parallel image array, and this block drains it through the narrow pad-limited output port. Optionally appends a checksum beat.

---
 rtl/fmap_serializer.sv | 169 ++++++++++++++++
 tb/tb_fmap_serializer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_serializer.sv
// fmap_serializer: captures the pooled binary feature maps in one cycle.
// It streams them out MSB first as OUT_W-bit beats over a valid/ready
// handshake. The first bit of the frame is img_in[0][IMG_SIZE*IMG_SIZE-1].
// Optional feature: define FMAP_SER_CHECKSUM_EN to append one trailer beat.
// The trailer holds the XOR of all data beats, including the zero padding.
module fmap_serializer #(
    parameter int IC       = 8,
    parameter int IMG_SIZE = 6,
    parameter int OUT_W    = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IMG_SIZE*IMG_SIZE-1:0]   img_in [0:IC-1],
    input  logic                           load,
    output logic                           busy,
    output logic [OUT_W-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           done
);

    localparam int CH_BITS = IMG_SIZE * IMG_SIZE;
    localparam int T_BITS  = IC * CH_BITS;
    localparam int NBEATS  = (T_BITS + OUT_W - 1) / OUT_W;
    localparam int SR_W    = NBEATS * OUT_W;
`ifdef FMAP_SER_CHECKSUM_EN
    localparam int FRAME_BEATS = NBEATS + 1;
`else
    localparam int FRAME_BEATS = NBEATS;
`endif
    // Counter reaches NBEATS+1 without wrapping.
    localparam int CNT_W = $clog2(FRAME_BEATS + 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_BEATS - 1);
`ifdef FMAP_SER_CHECKSUM_EN
    localparam logic [CNT_W-1:0] TRAIL_IDX = CNT_W'(NBEATS);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [SR_W-1:0]    shift_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [OUT_W-1:0]   out_data_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic               busy_r;
    logic               done_r;
    logic [SR_W-1:0]    cap_s;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               hs_s;
`ifdef FMAP_SER_CHECKSUM_EN
    logic [OUT_W-1:0]   csum_r;

    // Running checksum update: XOR one more data beat into the accumulator.
    function automatic logic [OUT_W-1:0] fold_beat(input logic [OUT_W-1:0] acc,
                                                   input logic [OUT_W-1:0] beat);
        return acc ^ beat;
    endfunction
`endif

    // Flatten the channel array: channel 0 occupies the MSBs, padding sits in the LSBs.
    always_comb begin
        cap_s = '0;
        for (int c = 0; c < IC; c++) begin
            cap_s[SR_W-1-c*CH_BITS -: CH_BITS] = img_in[c];
        end
    end

    // Handshake and next beat index.
    always_comb begin
        hs_s      = out_valid_r & out_ready;
        cnt_nxt_s = cnt_r + CNT_ONE;
    end

    // Frame FSM: capture, stream beats, then emit a one-cycle done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            shift_r     <= '0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef FMAP_SER_CHECKSUM_EN
            csum_r      <= '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (load) begin
                        // Beat 0 goes straight to the output register; the rest waits in shift_r.
                        shift_r     <= cap_s << OUT_W;
                        out_data_r  <= cap_s[SR_W-1 -: OUT_W];
                        cnt_r       <= '0;
                        out_valid_r <= 1'b1;
                        out_last_r  <= (LAST_IDX == '0);
                        busy_r      <= 1'b1;
                        state_r     <= ST_SEND;
`ifdef FMAP_SER_CHECKSUM_EN
                        csum_r      <= '0;
`endif
                    end else begin
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (hs_s && out_last_r) begin
                        out_data_r  <= '0;
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        done_r      <= 1'b1;
                        cnt_r       <= cnt_nxt_s;
                        state_r     <= ST_DONE;
                    end else if (hs_s) begin
                        cnt_r      <= cnt_nxt_s;
                        shift_r    <= shift_r << OUT_W;
                        out_last_r <= (cnt_nxt_s == LAST_IDX);
`ifdef FMAP_SER_CHECKSUM_EN
                        csum_r     <= fold_beat(csum_r, out_data_r);
                        if (cnt_nxt_s == TRAIL_IDX) begin
                            out_data_r <= fold_beat(csum_r, out_data_r);
                        end else begin
                            out_data_r <= shift_r[SR_W-1 -: OUT_W];
                        end
`else
                        out_data_r <= shift_r[SR_W-1 -: OUT_W];
`endif
                    end else begin
                        // Stall: hold the presented beat.
                        state_r <= ST_SEND;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_data_r  <= '0;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_fmap_serializer.sv
// Self-checking bench for fmap_serializer: directed and random frames are
// checked against a bit-queue reference model. A second, small instance
// exercises the padding of the last beat.
module tb_fmap_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [35:0] img [0:7];
    logic        load;
    logic        busy;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;

    logic [24:0] img2 [0:0];
    logic        load2;
    logic        busy2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic        out_last2;
    logic        done2;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    fmap_serializer #(.IC(8), .IMG_SIZE(6), .OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .img_in(img), .load(load), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    fmap_serializer #(.IC(1), .IMG_SIZE(5), .OUT_W(8)) dut_pad (
        .clk(clk), .rst_n(rst_n), .img_in(img2), .load(load2), .busy(busy2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_last(out_last2), .done(done2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: lay the frame out as a bit list, pad with zeros, cut into bytes.
    task automatic build_exp();
        bit         bits[$];
        logic [7:0] b;
        logic [7:0] x;
        exp_q.delete();
        for (int c = 0; c < 8; c++)
            for (int i = 35; i >= 0; i--) bits.push_back(img[c][i]);
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        x = 8'h00;
        for (int k = 0; k < bits.size() / 8; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) b = {b[6:0], bits[k*8+j]};
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef FMAP_SER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic randomize_img();
        for (int c = 0; c < 8; c++) img[c] = {$urandom, $urandom} & 64'hF_FFFF_FFFF;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"},  out_data,  8'h00);
        chk({tag, "_last"},  out_last,  1'b0);
        chk({tag, "_busy"},  busy,      1'b0);
        chk({tag, "_done"},  done,      1'b0);
    endtask

    // One frame on the main instance; bp applies the 1,0,0,1 ready pattern,
    // poke pulses load mid-frame, timing checks the exact done cycle.
    task automatic run_frame(input bit bp, input bit poke, input bit timing);
        int         idx;
        int         cyc;
        bit         got_done;
        logic [3:0] pat;
        pat = 4'b1001;
        build_exp();
        idx = 0;
        cyc = 0;
        got_done = 1'b0;
        @(negedge clk);
        load = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        while (!got_done && cyc < 600) begin
            if (out_valid) begin
                if (idx < exp_q.size()) begin
                    chk("beat_data", out_data, exp_q[idx]);
                    chk("beat_last", out_last, (idx == exp_q.size() - 1));
                end else begin
                    chk("beat_overrun", idx, exp_q.size() - 1);
                end
                chk("busy_send", busy, 1'b1);
                chk("done_in_send", done, 1'b0);
                out_ready = bp ? pat[3 - (cyc % 4)] : 1'b1;
                if (out_ready) idx++;
            end else if (done) begin
                chk("beat_count", idx, exp_q.size());
                chk("busy_done", busy, 1'b1);
                if (timing) chk("done_cycle", cyc, exp_q.size());
                got_done = 1'b1;
            end else begin
                chk("valid_gap", out_valid, 1'b1);
            end
            load = poke && (cyc == 3);
            if (cyc == 5) randomize_img();
            @(negedge clk);
            cyc++;
        end
        load = 1'b0;
        out_ready = 1'b1;
        chk("frame_done_seen", got_done, 1'b1);
        check_idle("post_frame");
    endtask

    initial begin
        logic [7:0] pad_exp[$];
        int         pidx;
        bit         pdone;

        rst_n = 1'b0;
        load = 1'b0;
        load2 = 1'b0;
        out_ready = 1'b0;
        out_ready2 = 1'b1;
        for (int c = 0; c < 8; c++) img[c] = '0;
        img2[0] = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        chk("reset_pad_valid", out_valid2, 1'b0);
        rst_n = 1'b1;

        // All ones, free-running sink, exact cycle timing.
        for (int c = 0; c < 8; c++) img[c] = 36'hF_FFFF_FFFF;
        run_frame(1'b0, 1'b0, 1'b1);

        // Bit order: first wire bit, then last data bit.
        for (int c = 0; c < 8; c++) img[c] = '0;
        img[0][35] = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) img[c] = '0;
        img[7][0] = 1'b1;
        run_frame(1'b0, 1'b0, 1'b1);

        // Random frames, with backpressure and an ignored mid-frame load.
        randomize_img();
        run_frame(1'b1, 1'b1, 1'b0);
        randomize_img();
        run_frame(1'b0, 1'b1, 1'b1);
        randomize_img();
        run_frame(1'b1, 1'b0, 1'b0);

        // Reset mid-frame after 10 beats.
        randomize_img();
        build_exp();
        @(negedge clk);
        load = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_reset_beat", out_data, exp_q[10]);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_reset_done", done, 1'b0);
            chk("after_reset_valid", out_valid, 1'b0);
        end
        randomize_img();
        run_frame(1'b0, 1'b0, 1'b1);

        // Padding on the small instance: 25 ones -> FF FF FF 80.
        pad_exp = '{8'hFF, 8'hFF, 8'hFF, 8'h80};
`ifdef FMAP_SER_CHECKSUM_EN
        pad_exp.push_back(8'h7F);
`endif
        img2[0] = 25'h1FF_FFFF;
        pidx = 0;
        pdone = 1'b0;
        @(negedge clk);
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        for (int cyc = 0; cyc < 20 && !pdone; cyc++) begin
            if (out_valid2) begin
                if (pidx < pad_exp.size()) begin
                    chk("pad_data", out_data2, pad_exp[pidx]);
                    chk("pad_last", out_last2, (pidx == pad_exp.size() - 1));
                end else begin
                    chk("pad_overrun", pidx, pad_exp.size() - 1);
                end
                pidx++;
            end else if (done2) begin
                chk("pad_count", pidx, pad_exp.size());
                pdone = 1'b1;
            end else begin
                chk("pad_gap", out_valid2, 1'b1);
            end
            @(negedge clk);
        end
        chk("pad_done_seen", pdone, 1'b1);
        chk("pad_idle_busy", busy2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
